enemy_fleet_ctrl: RTL
=====================

# enemy_fleet_ctrl

Sequencer for the enemy formation: owns one shared formation origin, per-enemy alive mask, march cadence, wall bounce, descent and end-of-wave detection. Sits between the frame tick / bullet-hit logic and the per-enemy draw instances. Each instance renders at origin + (col, row) × CELL_P and is drawn only when its alive bit is set. Replaces per-enemy free-running motion so the whole fleet moves in lockstep and speeds up as enemies die.

## Interface
- COLS_P, 8, formation columns
- ROWS_P, 4, formation rows; N = COLS_P*ROWS_P (≤ 64)
- CELL_P, 40, pixel pitch of one enemy cell; W = COLS_P*CELL_P, H = ROWS_P*CELL_P
- STEP_P, 2, horizontal pixels per march step
- DROP_P, 40, vertical pixels per descent
- H_RES_P, 640, screen width
- LAND_Y_P, 440, fleet bottom edge limit (y + H must not exceed it)
- START_X_P, 0 / START_Y_P, 0, origin after reset
- clk_i  in  1  system/pixel clock
- reset_i  in  1  synchronous, active-high reset
- frame_i  in  1  one-cycle pulse per video frame
- kill_valid_i  in  1  hit report strobe
- kill_idx_i  in  6  enemy index hit (row*COLS_P + col)
- kill_ack_o  out  1  pulse: kill accepted
- alive_o  out  N  alive mask, bit i = enemy i
- alive_cnt_o  out  7  number of alive enemies
- fleet_x_o  out  10  formation origin x (top-left)
- fleet_y_o  out  10  formation origin y
- dir_o  out  1  0 = moving right, 1 = moving left
- step_o  out  1  pulse: formation moved this cycle
- landed_o  out  1  sticky: fleet reached LAND_Y_P
- cleared_o  out  1  sticky: all enemies dead

## Operation
- States: MARCH, DROP, LANDED, CLEARED. Reset → MARCH.
- Reset values: x=START_X_P, y=START_Y_P, alive_o all ones, alive_cnt_o=N, dir_o=0, frame counter 0, all pulse/sticky outputs 0.
- Cadence: period = 1 + (alive_cnt_o >> 3) frames, using the registered count. On frame_i: if counter == period-1, then counter ← 0 and a step event fires; otherwise counter increments. If period shrinks below counter+1, the step fires on the next frame_i and the counter wraps to 0.
- MARCH step, dir 0: if x + W + STEP_P > H_RES_P-1, then x ← H_RES_P-1-W, dir ← 1, go to DROP. Otherwise x ← x + STEP_P.
- MARCH step, dir 1: if x < STEP_P, then x ← 0, dir ← 0, go to DROP. Otherwise x ← x - STEP_P.
- DROP step: if y + DROP_P + H > LAND_Y_P, then y ← LAND_Y_P - H, landed_o ← 1, go to LANDED. Otherwise y ← y + DROP_P and return to MARCH.
- step_o pulses on every step event that occurs in MARCH or DROP.
- LANDED and CLEARED are terminal until reset. They produce no steps and position is frozen. In LANDED, kills are still accepted. In CLEARED, no enemy is alive.
- Kill handling: accepted only if kill_valid_i, kill_idx_i < N, and alive bit set. On acceptance: clear the bit, decrement the count, pulse kill_ack_o. Otherwise the kill is ignored and no ack is issued.
- When the count reaches 0: cleared_o ← 1, go to CLEARED.
- Simultaneous kill and step: both apply; cadence uses the pre-kill count.
- Simultaneous clear and landing: CLEARED wins and landed_o stays 0.

## Timing
- All outputs registered.
- step_o, x, y and dir update in the cycle after the qualifying frame_i (1-cycle latency).
- kill_ack_o, alive_o and alive_cnt_o update 1 cycle after kill_valid_i. cleared_o updates in the same cycle.
- One kill per cycle maximum; back-to-back kills on consecutive cycles are each processed.
- Arithmetic: edge comparisons are done at 11 bits so x + W + STEP_P cannot wrap.
- reset_i mid-operation, in any state: all state returns to reset values on the next edge. reset_i overrides any same-cycle kill or frame event.

## Test plan
- Reset, then 5 frame_i pulses: no step_o on pulses 1-4. On pulse 5, step_o=1 and x=2 (period 5 with 32 alive).
- Preload march to x=318, dir 0: next step gives x=319, dir=1, state DROP. Next step gives y=40, x unchanged. Following step gives x=317.
- Kill idx 5 → kill_ack_o=1, alive_o[5]=0, alive_cnt_o=31. Kill idx 5 again → no ack, count 31. Kill idx 40 → ignored.
- Kill 25 enemies (count 7) → period 1: step_o fires on every frame_i.
- Drive drops from y=0: y goes 40, 80 … 280. The next drop gives y=280, landed_o=1, and no further steps. Kills are still acked.
- Kill all 32, with the last kill coinciding with a landing drop → cleared_o=1 and landed_o=0. Assert reset_i → all reset values restored on the next cycle.

Source files
------------

// File: rtl/enemy_fleet_ctrl.sv
// Enemy formation sequencer: shared origin, alive mask, cadence-driven march,
// wall bounce, descent, and landed/cleared end-of-wave detection.
module enemy_fleet_ctrl #(
  parameter int unsigned COLS_P    = 8,
  parameter int unsigned ROWS_P    = 4,
  parameter int unsigned CELL_P    = 40,
  parameter int unsigned STEP_P    = 2,
  parameter int unsigned DROP_P    = 40,
  parameter int unsigned H_RES_P   = 640,
  parameter int unsigned LAND_Y_P  = 440,
  parameter int unsigned START_X_P = 0,
  parameter int unsigned START_Y_P = 0
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       frame_i,
  input  logic                       kill_valid_i,
  input  logic [5:0]                 kill_idx_i,
  output logic                       kill_ack_o,
  output logic [COLS_P*ROWS_P-1:0]   alive_o,
  output logic [6:0]                 alive_cnt_o,
  output logic [9:0]                 fleet_x_o,
  output logic [9:0]                 fleet_y_o,
  output logic                       dir_o,
  output logic                       step_o,
  output logic                       landed_o,
  output logic                       cleared_o
);

  localparam int unsigned N = COLS_P * ROWS_P;
  localparam int unsigned W = COLS_P * CELL_P;
  localparam int unsigned H = ROWS_P * CELL_P;

  localparam logic [10:0] RIGHT_LIM = 11'(H_RES_P - 1);
  localparam logic [10:0] W_STEP    = 11'(W + STEP_P);
  localparam logic [9:0]  X_RIGHT   = 10'(H_RES_P - 1 - W);
  localparam logic [9:0]  STEP_X    = 10'(STEP_P);
  localparam logic [10:0] DROP_H    = 11'(DROP_P + H);
  localparam logic [10:0] LAND_LIM  = 11'(LAND_Y_P);
  localparam logic [9:0]  Y_LAND    = 10'(LAND_Y_P - H);
  localparam logic [9:0]  DROP_Y    = 10'(DROP_P);
  localparam logic [6:0]  N_CNT     = 7'(N);

  typedef enum logic [1:0] {MARCH, DROP, LANDED, CLEARED} state_t;

  state_t         state_q, state_d;
  logic [3:0]     frame_cnt_q, frame_cnt_d;
  logic [3:0]     period;
  logic           step_evt;
  logic           kill_ok;
  logic [63:0]    alive_ext;
  logic [63:0]    kill_mask;
  logic [10:0]    x_ext, y_ext;

  logic           kill_ack_d, step_d, dir_d, landed_d, cleared_d;
  logic [N-1:0]   alive_d;
  logic [6:0]     alive_cnt_d;
  logic [9:0]     fleet_x_d, fleet_y_d;

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    kill_ack_d  = 1'b0;
    step_d      = 1'b0;
    dir_d       = dir_o;
    landed_d    = landed_o;
    cleared_d   = cleared_o;
    alive_d     = alive_o;
    alive_cnt_d = alive_cnt_o;
    fleet_x_d   = fleet_x_o;
    fleet_y_d   = fleet_y_o;

    // Cadence uses the registered (pre-kill) count; >= catches a shrunken period.
    period   = 4'd1 + 4'(alive_cnt_o >> 3);
    step_evt = frame_i && (({1'b0, frame_cnt_q} + 5'd1) >= {1'b0, period});
    if (frame_i) begin
      frame_cnt_d = step_evt ? '0 : frame_cnt_q + 4'd1;
    end

    x_ext = {1'b0, fleet_x_o};
    y_ext = {1'b0, fleet_y_o};

    unique case (state_q)
      MARCH: begin
        if (step_evt) begin
          step_d = 1'b1;
          if (!dir_o) begin
            if (x_ext + W_STEP > RIGHT_LIM) begin
              fleet_x_d = X_RIGHT;
              dir_d     = 1'b1;
              state_d   = DROP;
            end else begin
              fleet_x_d = fleet_x_o + STEP_X;
            end
          end else begin
            if (fleet_x_o < STEP_X) begin
              fleet_x_d = '0;
              dir_d     = 1'b0;
              state_d   = DROP;
            end else begin
              fleet_x_d = fleet_x_o - STEP_X;
            end
          end
        end
      end
      DROP: begin
        if (step_evt) begin
          step_d = 1'b1;
          if (y_ext + DROP_H > LAND_LIM) begin
            fleet_y_d = Y_LAND;
            landed_d  = 1'b1;
            state_d   = LANDED;
          end else begin
            fleet_y_d = fleet_y_o + DROP_Y;
            state_d   = MARCH;
          end
        end
      end
      LANDED:  ;
      CLEARED: ;
      default: state_d = MARCH;
    endcase

    alive_ext = 64'(alive_o);
    kill_mask = 64'd1 << kill_idx_i;
    kill_ok   = kill_valid_i && ({1'b0, kill_idx_i} < N_CNT) && alive_ext[kill_idx_i];

    // The final kill overrides any same-cycle landing: CLEARED wins.
    if (kill_ok) begin
      kill_ack_d  = 1'b1;
      alive_d     = alive_o & ~N'(kill_mask);
      alive_cnt_d = alive_cnt_o - 7'd1;
      if (alive_cnt_o == 7'd1) begin
        cleared_d = 1'b1;
        landed_d  = landed_o;
        state_d   = CLEARED;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= MARCH;
      frame_cnt_q <= '0;
      kill_ack_o  <= 1'b0;
      step_o      <= 1'b0;
      dir_o       <= 1'b0;
      landed_o    <= 1'b0;
      cleared_o   <= 1'b0;
      alive_o     <= '1;
      alive_cnt_o <= N_CNT;
      fleet_x_o   <= 10'(START_X_P);
      fleet_y_o   <= 10'(START_Y_P);
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      kill_ack_o  <= kill_ack_d;
      step_o      <= step_d;
      dir_o       <= dir_d;
      landed_o    <= landed_d;
      cleared_o   <= cleared_d;
      alive_o     <= alive_d;
      alive_cnt_o <= alive_cnt_d;
      fleet_x_o   <= fleet_x_d;
      fleet_y_o   <= fleet_y_d;
    end
  end

endmodule
